// File: rtl/regfile_scan_pkg.sv
// ============================================================================
// Module      : regfile_scan_pkg
// Description : Shared types and constants for the register-file readback
//               scanner: scan FSM states and the hex seven-segment table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/regfile_readback_scan_seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import regfile_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] cath
);

    assign cath = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/regfile_readback_scan.sv
// ============================================================================
// Module      : regfile_readback_scan
// Description : Walks the register file read port, holding each word on the
//               4-digit multiplexed display. Optional Fibonacci consistency
//               check enabled by defining FIB_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_readback_scan
    import regfile_scan_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int NUM_REGS       = 16,
    parameter int ADDR_W         = 4,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REFRESH_CYCLES = 50_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [3:0]        an,
    output logic [6:0]        cath,
    output logic              mismatch
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   shown_q, shown_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [REF_W-1:0]    refresh_cnt_q, refresh_cnt_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          cath_q, cath_d;
    logic [3:0]          nibble_d;
    logic                scan_start;

    assign scan_start = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        cur_addr_d = cur_addr_q;
        shown_d    = shown_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                end
            end
            READ: begin
                state_d    = HOLD;
                shown_d    = rd_data;
                cur_addr_d = rd_addr_q;
                hold_cnt_d = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else if (rd_addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    state_d   = READ;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == READ) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    // Display path is fed from next-state values so an/cath track the
    // digit index and shown word with no extra cycle of lag.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + REF_W'(1);
        digit_d       = digit_q;
        if (refresh_cnt_q == REF_LAST) begin
            refresh_cnt_d = '0;
            digit_d       = digit_q + DIGIT_W'(1);
        end
        nibble_d = shown_d[{digit_d, 2'b00} +: 4];
        an_d     = ~(4'b0001 << digit_d);
    end

    seg7_decode u_seg7_decode (
        .nibble (nibble_d),
        .cath   (cath_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            cur_addr_q    <= '0;
            shown_q       <= '0;
            hold_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            refresh_cnt_q <= '0;
            digit_q       <= '0;
            an_q          <= 4'b1110;
            cath_q        <= 7'b1000000;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            cur_addr_q    <= cur_addr_d;
            shown_q       <= shown_d;
            hold_cnt_q    <= hold_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_q       <= digit_d;
            an_q          <= an_d;
            cath_q        <= cath_d;
        end
    end

`ifdef FIB_CHECK_EN
    logic [DATA_W-1:0] prev1_q, prev1_d;
    logic [DATA_W-1:0] prev2_q, prev2_d;
    logic              mismatch_q, mismatch_d;

    // Sum is evaluated at DATA_W bits, giving the mod 2^16 wrap.
    always_comb begin
        prev1_d    = prev1_q;
        prev2_d    = prev2_q;
        mismatch_d = mismatch_q;
        if (scan_start) begin
            mismatch_d = 1'b0;
        end else if (state_q == READ) begin
            prev1_d = rd_data;
            prev2_d = prev1_q;
            if ((rd_addr_q >= ADDR_W'(2)) && (rd_data != (prev1_q + prev2_q))) begin
                mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev1_q    <= '0;
            prev2_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            prev1_q    <= prev1_d;
            prev2_q    <= prev2_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign rd_addr  = rd_addr_q;
    assign cur_addr = cur_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign an       = an_q;
    assign cath     = cath_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_readback_scan.sv
// ============================================================================
// Module      : tb_regfile_readback_scan
// Description : Self-checking bench for regfile_readback_scan (HOLD=4,
//               REFRESH=2); honours FIB_CHECK_EN for mismatch expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_readback_scan;

    localparam int HOLD    = 4;
    localparam int REFRESH = 2;
    localparam int NREG    = 16;
    localparam int PER     = HOLD + 1;
`ifdef FIB_CHECK_EN
    localparam bit FIB = 1'b1;
`else
    localparam bit FIB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [3:0]  cur_addr;
    logic [3:0]  an;
    logic [6:0]  cath;
    logic        mismatch;
    logic [15:0] regs [NREG];

    assign rd_data = regs[rd_addr];

    regfile_readback_scan #(
        .DATA_W         (16),
        .NUM_REGS       (NREG),
        .ADDR_W         (4),
        .HOLD_CYCLES    (HOLD),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .cur_addr (cur_addr),
        .an       (an),
        .cath     (cath),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int start_cyc = 0;

    typedef struct {
        int addr;
        int offset;
        bit mm;
    } sb_t;
    sb_t sbq[$];
    sb_t e;

    typedef struct {
        logic [3:0] an;
        logic [6:0] cath;
    } disp_t;
    disp_t dtab [12];

    logic       last_busy = 1'b0;
    logic [3:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each new read address pops one expected record: address, cycle offset
    // from the start-sampling edge, and sticky mismatch state at that point.
    always @(negedge clk) begin
        if (!reset && busy && (!last_busy || rd_addr != last_addr)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got addr %0d expected no read", rd_addr);
            end else begin
                e = sbq.pop_front();
                chk("sb_addr", rd_addr, e.addr);
                chk("sb_offset", cyc - start_cyc, e.offset);
                chk("sb_mismatch", mismatch, e.mm);
                if (e.addr > 0) chk("sb_cur_addr", cur_addr, e.addr - 1);
            end
        end
        last_busy = busy;
        last_addr = rd_addr;
    end

    task automatic load_fib();
        regs[0] = 16'd1;
        regs[1] = 16'd1;
        for (int i = 2; i < NREG; i++) regs[i] = regs[i-1] + regs[i-2];
    endtask

    task automatic pulse_start_and_queue(input int bad);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc + 1;
        for (int k = 0; k < NREG; k++) sbq.push_back('{k, k * PER, FIB && (bad < k)});
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
    endtask

    task automatic run_scan(input int bad, input bit mid);
        int n;
        pulse_start_and_queue(bad);
        if (mid) begin
            n = 0;
            while (!(busy && rd_addr == 4'd3) && n < 100) begin @(negedge clk); n++; end
            chk("mid_wait", n < 100, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        chk("done_offset", cyc - start_cyc, NREG * PER);
        chk("done_busy", busy, 0);
        chk("sb_drained", sbq.size(), 0);
        chk("done_mismatch", mismatch, FIB && (bad < NREG));
        chk("done_cur_addr", cur_addr, NREG - 1);
        sbq.delete();
    endtask

    task automatic check_disp(input int first, input int cnt);
        int n;
        n = 0;
        while (an == 4'b1110 && n < 20) begin @(negedge clk); n++; end
        while (an != 4'b1110 && n < 20) begin @(negedge clk); n++; end
        chk("disp_sync", n < 20, 1);
        for (int i = first; i < first + cnt; i++) begin
            chk("disp_an", an, dtab[i].an);
            chk("disp_cath", cath, dtab[i].cath);
            repeat (REFRESH) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 0x03DB shown as digits B,D,3,0 then 0xA5C3 twice as 3,C,5,A.
        dtab[0]  = '{4'b1110, 7'h03};
        dtab[1]  = '{4'b1101, 7'h21};
        dtab[2]  = '{4'b1011, 7'h30};
        dtab[3]  = '{4'b0111, 7'h40};
        dtab[4]  = '{4'b1110, 7'h30};
        dtab[5]  = '{4'b1101, 7'h46};
        dtab[6]  = '{4'b1011, 7'h12};
        dtab[7]  = '{4'b0111, 7'h08};
        dtab[8]  = '{4'b1110, 7'h30};
        dtab[9]  = '{4'b1101, 7'h46};
        dtab[10] = '{4'b1011, 7'h12};
        dtab[11] = '{4'b0111, 7'h08};
        load_fib();

        // Reset with start held: reset must win.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_cath", cath, 7'b1000000);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_cur_addr", cur_addr, 0);
        chk("rst_mismatch", mismatch, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run_scan(NREG, 1'b0);
        check_disp(0, 4);

        load_fib();
        regs[7] = 16'h0016;
        run_scan(7, 1'b1);

        load_fib();
        regs[15] = 16'hA5C3;
        run_scan(15, 1'b0);
        check_disp(4, 8);

        // Reset in the middle of HOLD for address 9.
        load_fib();
        pulse_start_and_queue(NREG);
        n = 0;
        while (!(busy && rd_addr == 4'd9) && n < 100) begin @(negedge clk); n++; end
        chk("hold9_wait", n < 100, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_rd_addr", rd_addr, 0);
        chk("mrst_cur_addr", cur_addr, 0);
        chk("mrst_an", an, 4'b1110);
        chk("mrst_cath", cath, 7'b1000000);
        chk("mrst_mismatch", mismatch, 0);
        sbq.delete();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_idle_busy", busy, 0);
        chk("mrst_zero_digit", cath, 7'b1000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
